// File: rtl/pipe_pkg.sv
// Shared types and defaults for the generic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } pipe_state_t;

  // Replicated to CTRL_W bits wherever a bubble is inserted.
  localparam logic CTRL_BUBBLE = 1'b0;

  localparam int CTRL_W_DEF = 8;
  localparam int DEST_W_DEF = 4;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic ready/valid pipeline stage: main entry plus optional skid entry,
// bubble-zeroed control field and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DEST_W = DEST_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cycles
);

  pipe_state_t r_state;
  pipe_state_t w_state_next;

  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DEST_W-1:0] r_out_dest;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DEST_W-1:0] r_skid_dest;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // With SKID=0 a FULL stage only accepts when out_ready is high, so the
  // in_fire & !out_fire branch below is reachable only in the skid variant.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_next   = FULL;
            w_load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_next = SKID_FULL;
            w_load_skid  = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = EMPTY;
          end
        end
        SKID_FULL: begin
          if (w_out_fire) begin
            w_state_next     = FULL;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    w_in_fire  = in_valid && w_in_ready;
    w_out_fire = r_out_valid && out_ready;
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_next != SKID_FULL);
        end
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = !r_out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_dest  <= '0;
      r_out_data  <= '0;
      r_skid_ctrl <= '0;
      r_skid_dest <= '0;
      r_skid_data <= '0;
    end else begin
      r_out_valid <= (w_state_next != EMPTY);
      // Bubbles always carry a zero control field; dest/data simply hold.
      if (w_state_next == EMPTY) begin
        r_out_ctrl <= {CTRL_W{CTRL_BUBBLE}};
      end else if (w_load_main_in) begin
        r_out_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_out_ctrl <= r_skid_ctrl;
      end
      if (w_load_main_in) begin
        r_out_dest <= in_dest;
        r_out_data <= in_data;
      end else if (w_load_main_skid) begin
        r_out_dest <= r_skid_dest;
        r_out_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_dest <= in_dest;
        r_skid_data <= in_data;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (r_out_valid && !out_ready),
    .clr  (clr_stats),
    .count(stall_cycles)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_ctrl;
  assign out_dest  = r_out_dest;
  assign out_data  = r_out_data;

endmodule
